// File: rtl/cpu_prog_sequencer_if.sv
// ---------------------------------------------------------------------------
// cpu_prog_sequencer_if
// Bus between the program sequencer and the pipelined CPU under test.
//   cpu_enable  : CPU enable, held for the whole run
//   cpu_start   : one-cycle CPU start pulse
//   i_datain    : instruction word presented to the CPU each clock
//   d_addr      : CPU data-memory address
//   d_dataout   : CPU data-memory write data
//   d_we        : CPU data-memory write enable
// master = sequencer side, slave = CPU side.
// ---------------------------------------------------------------------------
interface cpu_prog_sequencer_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8
);
    logic              cpu_enable;
    logic              cpu_start;
    logic [DATA_W-1:0] i_datain;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_dataout;
    logic              d_we;

    modport master (
        output cpu_enable, cpu_start, i_datain,
        input  d_addr, d_dataout, d_we
    );

    modport slave (
        input  cpu_enable, cpu_start, i_datain,
        output d_addr, d_dataout, d_we
    );
endinterface

// File: rtl/cpu_prog_sequencer.sv
// ---------------------------------------------------------------------------
// cpu_prog_sequencer
// Loads a program, brings the CPU up (enable, then a start pulse), streams
// one instruction per clock until HALT, drains the pipeline with NOPs and
// checks every CPU data write against a FIFO of expected writes.
//   clock, reset          : clock and synchronous active-high reset
//   prog_we/addr/data     : program memory write port (IDLE only)
//   exp_push/addr/data    : push an expected {d_addr, d_dataout}
//   exp_full              : expected-write FIFO full
//   go                    : start a run (ignored while busy)
//   bus (master)          : CPU enable/start/instruction and data-write bus
//   busy, done, pass      : run status; pass valid while done
//   overrun               : program ran off the end without HALT
//   err_count/cycle_count : saturating mismatch and RUN+DRAIN cycle counts
// ---------------------------------------------------------------------------
module cpu_prog_sequencer #(
    parameter int                DATA_W    = 16,
    parameter int                ADDR_W    = 8,
    parameter int                DEPTH     = 32,
    parameter int                EXP_DEPTH = 16,
    parameter int                OPC_W     = 5,
    parameter logic [OPC_W-1:0]  HALT_OPC  = 5'b00001,
    parameter logic [DATA_W-1:0] NOP_WORD  = 16'h0000,
    parameter int                DRAIN_CYC = 5,
    parameter int                CNT_W     = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     prog_we,
    input  logic [$clog2(DEPTH)-1:0] prog_addr,
    input  logic [DATA_W-1:0]        prog_data,
    input  logic                     exp_push,
    input  logic [ADDR_W-1:0]        exp_addr,
    input  logic [DATA_W-1:0]        exp_data,
    output logic                     exp_full,
    input  logic                     go,
    cpu_prog_sequencer_if.master     bus,
    output logic                     busy,
    output logic                     done,
    output logic                     pass,
    output logic                     overrun,
    output logic [CNT_W-1:0]         err_count,
    output logic [CNT_W-1:0]         cycle_count
);
    localparam int PC_W = $clog2(DEPTH);
    localparam int EA_W = $clog2(EXP_DEPTH);
    localparam int DC_W = $clog2(DRAIN_CYC + 1);
    localparam int EW   = ADDR_W + DATA_W;

    typedef enum logic [2:0] {S_IDLE, S_ARM, S_START, S_RUN, S_DRAIN, S_DONE} state_t;
    state_t state, state_nxt;

    logic [DATA_W-1:0] prog_mem [DEPTH];
    logic [EW-1:0]     exp_mem  [EXP_DEPTH];
    logic [PC_W-1:0]   pc;
    logic [DC_W-1:0]   drain_cnt;
    logic [EA_W-1:0]   rd_ptr, wr_ptr;
    logic [EA_W:0]     exp_cnt, exp_cnt_nxt;

    logic [DATA_W-1:0] issue_word;
    logic is_halt, last_pc, chk_active, exp_empty, exp_is_full;
    logic chk_pop, flush_pop, pop, push_req, push, push_drop, chk_err;
    logic [1:0] err_inc;

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                  input logic [1:0] inc);
        logic [CNT_W:0] sum;
        sum = {1'b0, a} + {{(CNT_W-1){1'b0}}, inc};
        return sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
    endfunction

    // Decode of the word at pc and of the checker/FIFO strobes
    always_comb begin
        issue_word  = prog_mem[pc];
        is_halt     = (issue_word[DATA_W-1 -: OPC_W] == HALT_OPC);
        last_pc     = (pc == PC_W'(DEPTH - 1));
        chk_active  = (state == S_ARM) || (state == S_START) ||
                      (state == S_RUN) || (state == S_DRAIN);
        exp_empty   = (exp_cnt == '0);
        exp_is_full = (exp_cnt == (EA_W+1)'(EXP_DEPTH));
        chk_pop     = chk_active && bus.d_we && !exp_empty;
        flush_pop   = (state == S_DONE) && !exp_empty;
        pop         = chk_pop || flush_pop;
        push_req    = exp_push && (state != S_DONE);
        // A pop in the same cycle frees the slot, so a push into a full FIFO
        // is only dropped when nothing leaves.
        push        = push_req && (!exp_is_full || pop);
        push_drop   = push_req && exp_is_full && !pop;
        chk_err     = chk_active && bus.d_we &&
                      (exp_empty || (exp_mem[rd_ptr] != {bus.d_addr, bus.d_dataout}));
        err_inc     = {1'b0, push_drop} + {1'b0, chk_err || flush_pop};
        exp_cnt_nxt = exp_cnt;
        if (push && !pop)
            exp_cnt_nxt = exp_cnt + (EA_W+1)'(1);
        else if (!push && pop)
            exp_cnt_nxt = exp_cnt - (EA_W+1)'(1);
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (go) state_nxt = S_ARM;
            S_ARM:   state_nxt = S_START;
            S_START: state_nxt = S_RUN;
            S_RUN:   if (is_halt || last_pc) state_nxt = S_DRAIN;
            S_DRAIN: if (drain_cnt == DC_W'(DRAIN_CYC - 1)) state_nxt = S_DONE;
            S_DONE:  if (exp_empty) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // Registered outputs, counters and FIFO pointers
    always_ff @(posedge clock) begin
        if (reset) begin
            bus.cpu_enable <= 1'b0;
            bus.cpu_start  <= 1'b0;
            bus.i_datain   <= NOP_WORD;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            overrun        <= 1'b0;
            err_count      <= '0;
            cycle_count    <= '0;
            pc             <= '0;
            drain_cnt      <= '0;
            rd_ptr         <= '0;
            wr_ptr         <= '0;
            exp_cnt        <= '0;
            exp_full       <= 1'b0;
        end else begin
            bus.cpu_start <= (state == S_START);
            bus.i_datain  <= (state == S_RUN) ? issue_word : NOP_WORD;
            if (state == S_ARM)
                bus.cpu_enable <= 1'b1;
            else if ((state == S_DONE) && exp_empty)
                bus.cpu_enable <= 1'b0;

            case (state)
                S_IDLE: if (go) begin
                    busy      <= 1'b1;
                    done      <= 1'b0;
                    pass      <= 1'b0;
                    overrun   <= 1'b0;
                    pc        <= '0;
                    drain_cnt <= '0;
                end
                S_RUN: begin
                    drain_cnt <= '0;
                    // pc parks on the last word instead of wrapping
                    if (!last_pc) pc <= pc + PC_W'(1);
                    if (last_pc && !is_halt) overrun <= 1'b1;
                end
                S_DRAIN: drain_cnt <= drain_cnt + DC_W'(1);
                S_DONE: if (exp_empty) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                    pass <= (err_count == '0) && !overrun;
                end
                default: ;
            endcase

            if ((state == S_IDLE) && go)
                cycle_count <= '0;
            else if ((state == S_RUN) || (state == S_DRAIN))
                cycle_count <= sat_add(cycle_count, 2'd1);

            if ((state == S_IDLE) && go)
                err_count <= '0;
            else
                err_count <= sat_add(err_count, err_inc);

            if (pop)  rd_ptr <= rd_ptr + EA_W'(1);
            if (push) wr_ptr <= wr_ptr + EA_W'(1);
            exp_cnt  <= exp_cnt_nxt;
            exp_full <= (exp_cnt_nxt == (EA_W+1)'(EXP_DEPTH));
        end
    end

    // Storage arrays carry no reset; program contents survive reset
    always_ff @(posedge clock) begin
        if (prog_we && (state == S_IDLE))
            prog_mem[prog_addr] <= prog_data;
        if (push)
            exp_mem[wr_ptr] <= {exp_addr, exp_data};
    end
endmodule
